can_bit_timing: RTL and testbench

CAN_BIT_TIMING -- requirements
Module: can_bit_timing

---
 rtl/can_bit_timing.sv | 191 +++++++++++++++++++
 tb/tb_can_bit_timing.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/can_bit_timing.sv
// CAN bit timing logic: synchronises the raw RX pin, splits every bit into
// SYNC / TSEG1 / TSEG2 time quanta, and flags the TX change point and the
// sample point. Hard synchronisation is always present.
// Define CAN_BTL_RESYNC_EN to add soft resynchronisation (segment lengthening
// and shortening limited by the jump width). Without it, every bit has the
// nominal length.
module can_bit_timing #(
   parameter int SYNC_STAGES = 2   // RX synchroniser depth, at least 2
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       enable,
   input  logic [5:0] brp,
   input  logic [3:0] tseg1,
   input  logic [2:0] tseg2,
   input  logic [1:0] sjw,
   input  logic       hard_sync_en,
   input  logic       rx_i,
   output logic       tx_point,
   output logic       sample_point,
   output logic       sampled_bit
);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TSEG1 = 2'd1,
      ST_TSEG2 = 2'd2
   } state_t;

   // RX synchroniser and edge detection
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic                   prev_rx;
   logic                   run;
   logic                   rx_edge;
   logic                   hard_edge;

   // Bit timing state. seg_last_q is the index of the final tq of the
   // current segment; resynchronisation moves it, so the counter itself
   // never has to jump.
   state_t     state_q, state_d;
   logic [5:0] presc_q, presc_d;
   logic [5:0] brp_q, brp_d;
   logic [4:0] tq_q, tq_d;
   logic [4:0] seg_last_q, seg_last_d;
   logic       tq_tick;
   logic       seg_end;

`ifdef CAN_BTL_RESYNC_EN
   logic       resync_q, resync_d;
   logic       soft_edge;
   logic [4:0] sjw_tq;
   logic [4:0] err;
   logic [4:0] corr;
`else
   // The jump width only matters when soft resynchronisation is built in.
   logic       unused_sjw;
   assign unused_sjw = ^sjw;
`endif

   // Holding enable low behaves exactly like reset.
   assign run       = enable && !wb_rst_i;
   assign rx_s      = sync_q[SYNC_STAGES-1];
   assign rx_edge   = run && prev_rx && !rx_s;
   assign hard_edge = rx_edge && hard_sync_en;

   assign tq_tick = (presc_q == brp_q);
   // >= rather than == so a segment shortened below the current tq count
   // still ends on the next tick.
   assign seg_end = tq_tick && (tq_q >= seg_last_q);

   // Outputs are gated by run so nothing pulses while the block is held in
   // reset; the held SYNC state then produces tx_point on the first free clock.
   assign tx_point     = run && (state_q == ST_SYNC) && (presc_q == 6'd0) && (tq_q == 5'd0);
   assign sample_point = run && (state_q == ST_TSEG1) && seg_end;

`ifdef CAN_BTL_RESYNC_EN
   assign sjw_tq    = {3'b000, sjw} + 5'd1;
   assign soft_edge = rx_edge && !hard_sync_en && !resync_q;
`endif

   // Next-state logic: prescaler, tq counter, segment sequencing and sync.
   always_comb begin
      // NOTE: every variable gets a default before any branch so that no
      // path leaves it unassigned, which would infer a latch.
      state_d    = state_q;
      presc_d    = tq_tick ? 6'd0 : presc_q + 6'd1;
      brp_d      = tq_tick ? brp : brp_q;
      tq_d       = tq_tick ? tq_q + 5'd1 : tq_q;
      seg_last_d = seg_last_q;
`ifdef CAN_BTL_RESYNC_EN
      // The resync allowance is renewed at every sample point.
      resync_d   = sample_point ? 1'b0 : resync_q;
      err        = 5'd0;
      corr       = 5'd0;
`endif

      if (seg_end) begin
         tq_d = 5'd0;
         unique case (state_q)
            ST_SYNC: begin
               state_d    = ST_TSEG1;
               seg_last_d = {1'b0, tseg1};
            end
            ST_TSEG1: begin
               state_d    = ST_TSEG2;
               seg_last_d = {2'b00, tseg2};
            end
            default: begin
               state_d    = ST_SYNC;
               seg_last_d = 5'd0;
            end
         endcase
      end

`ifdef CAN_BTL_RESYNC_EN
      if (soft_edge) begin
         if ((state_q == ST_TSEG1) && !sample_point) begin
            // Late edge: stretch TSEG1 by the completed tq, capped at sjw+1.
            err        = tq_q;
            corr       = (err < sjw_tq) ? err : sjw_tq;
            seg_last_d = seg_last_q + corr;
            resync_d   = 1'b1;
         end else if (state_q != ST_SYNC) begin
            // Early edge: shorten TSEG2 by the remaining tq, capped at sjw+1.
            // An edge on the sample-point clock sees the whole of TSEG2 ahead.
            err      = (state_q == ST_TSEG1) ? {2'b00, tseg2} + 5'd1
                                             : seg_last_q - tq_q + 5'd1;
            corr     = (err < sjw_tq) ? err : sjw_tq;
            resync_d = 1'b1;
            if (corr >= err) begin
               // Nothing of TSEG2 left: the edge starts the next bit's TSEG1.
               state_d    = ST_TSEG1;
               tq_d       = 5'd0;
               presc_d    = 6'd0;
               brp_d      = brp;
               seg_last_d = {1'b0, tseg1};
            end else begin
               seg_last_d = ((state_q == ST_TSEG1) ? {2'b00, tseg2} : seg_last_q) - corr;
            end
         end
      end
`endif

      // Hard sync wins over everything: restart the bit at the top of TSEG1.
      if (hard_edge) begin
         state_d    = ST_TSEG1;
         tq_d       = 5'd0;
         presc_d    = 6'd0;
         brp_d      = brp;
         seg_last_d = {1'b0, tseg1};
`ifdef CAN_BTL_RESYNC_EN
         resync_d   = 1'b1;
`endif
      end
   end

   // State registers, RX synchroniser and sampled bit.
   always_ff @(posedge wb_clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge value of every other register.
      if (!run) begin
         sync_q      <= '1;
         prev_rx     <= 1'b1;
         state_q     <= ST_SYNC;
         presc_q     <= 6'd0;
         brp_q       <= brp;
         tq_q        <= 5'd0;
         seg_last_q  <= 5'd0;
         sampled_bit <= 1'b1;
`ifdef CAN_BTL_RESYNC_EN
         resync_q    <= 1'b0;
`endif
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
         prev_rx    <= rx_s;
         state_q    <= state_d;
         presc_q    <= presc_d;
         brp_q      <= brp_d;
         tq_q       <= tq_d;
         seg_last_q <= seg_last_d;
         if (sample_point) begin
            sampled_bit <= rx_s;
         end
`ifdef CAN_BTL_RESYNC_EN
         resync_q   <= resync_d;
`endif
      end
   end

endmodule

// File: tb/tb_can_bit_timing.sv
// Scoreboard bench for can_bit_timing. Directed phases push the expected
// tx_point / sample_point pulses (cycle relative to reset release, plus the
// expected sampled bit) into a queue; a monitor pops and compares on every
// pulse it sees.
module tb_can_bit_timing;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i;
   logic       enable;
   logic [5:0] brp;
   logic [3:0] tseg1;
   logic [2:0] tseg2;
   logic [1:0] sjw;
   logic       hard_sync_en;
   logic       rx_i;
   logic       tx_point;
   logic       sample_point;
   logic       sampled_bit;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int w     = 0;

   typedef struct {
      bit is_tx;
      int at;
      bit val;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_ev;
   bit  bit_pend = 1'b0;
   bit  bit_exp  = 1'b0;

   can_bit_timing #(.SYNC_STAGES(2)) dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .enable       (enable),
      .brp          (brp),
      .tseg1        (tseg1),
      .tseg2        (tseg2),
      .sjw          (sjw),
      .hard_sync_en (hard_sync_en),
      .rx_i         (rx_i),
      .tx_point     (tx_point),
      .sample_point (sample_point),
      .sampled_bit  (sampled_bit)
   );

   // 10 time-unit clock and a free-running cycle counter.
   always #5 wb_clk_i = ~wb_clk_i;
   always @(posedge wb_clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc - w);
      end
   endtask

   task automatic expect_ev(input bit is_tx, input int at, input bit val);
      ev_t e;
      e.is_tx = is_tx;
      e.at    = at;
      e.val   = val;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Reset, check the held state, load the configuration, release.
   task automatic phase_start(input int b, input int t1, input int t2,
                              input int s, input bit hs);
      wb_rst_i = 1'b1;
      step();
      #3;
      check("reset tx_point", tx_point, 0);
      check("reset sample_point", sample_point, 0);
      check("reset sampled_bit", sampled_bit, 1);
      brp          = 6'(b);
      tseg1        = 4'(t1);
      tseg2        = 3'(t2);
      sjw          = 2'(s);
      hard_sync_en = hs;
      rx_i         = 1'b1;
      enable       = 1'b1;
      step();
      step();
      wb_rst_i = 1'b0;
      w = cyc;
   endtask

   task automatic phase_end();
      check("events left over", exp_q.size(), 0);
      exp_q.delete();
      bit_pend = 1'b0;
   endtask

   // Monitor: every pulse must match the head of the queue.
   always @(negedge wb_clk_i) begin
      if (bit_pend) begin
         check("sampled_bit", sampled_bit, bit_exp);
         bit_pend = 1'b0;
      end
      if (tx_point || sample_point) begin
         if (exp_q.size() == 0) begin
            check("pulse with empty queue", int'(tx_point) + int'(sample_point), 0);
         end else begin
            mon_ev = exp_q.pop_front();
            check(tx_point ? "tx_point kind" : "sample_point kind", int'(tx_point), int'(mon_ev.is_tx));
            check("pulse cycle", cyc - w, mon_ev.at);
            if (!mon_ev.is_tx) begin
               bit_pend = 1'b1;
               bit_exp  = mon_ev.val;
            end
         end
      end
   end

   initial begin
      wb_rst_i     = 1'b1;
      enable       = 1'b1;
      brp          = 6'd0;
      tseg1        = 4'd3;
      tseg2        = 3'd2;
      sjw          = 2'd0;
      hard_sync_en = 1'b0;
      rx_i         = 1'b1;
      run(2);

      // Nominal timing, brp=0: 8-clock bit, sample 4 clocks after tx.
      phase_start(0, 3, 2, 0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         expect_ev(1'b1, 8 * k, 1'b1);
         expect_ev(1'b0, 8 * k + 4, 1'b1);
      end
      run(24);
      phase_end();

      // brp=1: 16-clock bit, sample on the last clock of TSEG1.
      phase_start(1, 3, 2, 0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         expect_ev(1'b1, 16 * k, 1'b1);
         expect_ev(1'b0, 16 * k + 9, 1'b1);
      end
      run(32);
      phase_end();

      // Hard sync: rx_s falls in TSEG2 at cycle 6, TSEG1 restarts at 7.
      phase_start(0, 3, 2, 0, 1'b1);
      expect_ev(1'b1, 0, 1'b1);
      expect_ev(1'b0, 4, 1'b1);
      expect_ev(1'b0, 10, 1'b0);
      expect_ev(1'b1, 14, 1'b0);
      expect_ev(1'b0, 18, 1'b0);
      run(4);
      rx_i = 1'b0;
      run(17);
      phase_end();

      // Edge after 2 TSEG1 tq, second edge on the sample clock.
      phase_start(0, 3, 2, 0, 1'b0);
`ifdef CAN_BTL_RESYNC_EN
      expect_ev(1'b1, 0, 1'b1);
      expect_ev(1'b0, 5, 1'b0);
      expect_ev(1'b1, 9, 1'b0);
      expect_ev(1'b0, 13, 1'b0);
      expect_ev(1'b1, 17, 1'b0);
`else
      expect_ev(1'b1, 0, 1'b1);
      expect_ev(1'b0, 4, 1'b1);
      expect_ev(1'b1, 8, 1'b0);
      expect_ev(1'b0, 12, 1'b0);
      expect_ev(1'b1, 16, 1'b0);
`endif
      run(1);
      rx_i = 1'b0;
      run(1);
      rx_i = 1'b1;
      run(1);
      rx_i = 1'b0;
      run(15);
      phase_end();

      // sjw=1, edge in the last TSEG2 tq (cycle 7).
      phase_start(0, 3, 2, 1, 1'b0);
`ifdef CAN_BTL_RESYNC_EN
      expect_ev(1'b1, 0, 1'b1);
      expect_ev(1'b0, 4, 1'b1);
      expect_ev(1'b0, 11, 1'b0);
      expect_ev(1'b1, 15, 1'b0);
      expect_ev(1'b0, 19, 1'b0);
`else
      expect_ev(1'b1, 0, 1'b1);
      expect_ev(1'b0, 4, 1'b1);
      expect_ev(1'b1, 8, 1'b0);
      expect_ev(1'b0, 12, 1'b0);
      expect_ev(1'b1, 16, 1'b0);
      expect_ev(1'b0, 20, 1'b0);
`endif
      run(5);
      rx_i = 1'b0;
      run(17);
      phase_end();

      // Reset pulsed on the sample-point clock of TSEG1.
      phase_start(0, 3, 2, 0, 1'b0);
      expect_ev(1'b1, 0, 1'b1);
      expect_ev(1'b1, 6, 1'b1);
      expect_ev(1'b0, 10, 1'b1);
      expect_ev(1'b1, 14, 1'b1);
      expect_ev(1'b0, 18, 1'b1);
      run(4);
      wb_rst_i = 1'b1;
      #3;
      check("mid-bit reset sample_point", sample_point, 0);
      check("mid-bit reset tx_point", tx_point, 0);
      step();
      #3;
      check("mid-bit reset sampled_bit", sampled_bit, 1);
      step();
      wb_rst_i = 1'b0;
      run(14);
      phase_end();

      // enable dropped during TSEG2 abandons the bit the same way.
      phase_start(0, 3, 2, 0, 1'b0);
      expect_ev(1'b1, 0, 1'b1);
      expect_ev(1'b0, 4, 1'b1);
      expect_ev(1'b1, 8, 1'b1);
      expect_ev(1'b0, 12, 1'b1);
      expect_ev(1'b1, 16, 1'b1);
      run(6);
      enable = 1'b0;
      #3;
      check("disabled tx_point", tx_point, 0);
      step();
      step();
      enable = 1'b1;
      run(10);
      phase_end();

      wb_rst_i = 1'b1;
      run(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
